// File: rtl/port_pkg.sv
// Shared definitions for the Z80 output-port path: FSM encoding and port constants.
package port_pkg;

  // Write-cycle FSM encoding
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    QUALIFY      = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Value driven on the port outputs out of reset
  localparam logic [7:0] PORT_RESET_VALUE = 8'h00;

  // I/O address of the output port FF, also used by the address decoder
  localparam logic [7:0] PORT_FF_ADDR = 8'hFF;

  // Width of the qualify counter; enough for a MIN_ASSERT of up to 15
  localparam int QUAL_CNT_W = 4;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic n_reset,
  input  logic d_in,
  output logic q_out
);

  logic [STAGES-1:0] chain_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_in};
    end
  end

  assign q_out = chain_q[STAGES-1];

endmodule

// File: rtl/out_port_latch.sv
// Output-port register: synchronizes the port-FF chip select and data bus,
// filters short select pulses and captures one byte per qualified OUT cycle.
module out_port_latch
  import port_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         MIN_ASSERT  = 2,
  parameter logic [7:0] RESET_VALUE = PORT_RESET_VALUE,
  parameter int         COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic                   port_cs,
  input  logic [7:0]             data_in,
  output logic [7:0]             port_out,
  output logic                   write_strobe,
  output logic [COUNT_WIDTH-1:0] write_count,
  output logic                   busy
);

  localparam logic [QUAL_CNT_W-1:0] MIN_ASSERT_W = QUAL_CNT_W'(MIN_ASSERT);

  logic                   s_cs;
  logic [7:0]             s_data;
  state_t                 state_q, state_d;
  logic [QUAL_CNT_W-1:0]  qual_cnt_q, qual_cnt_d;
  logic                   capture_en;
  logic [7:0]             port_out_q;
  logic                   write_strobe_q;
  logic [COUNT_WIDTH-1:0] write_count_q;

  // Chip select and data use equal-depth chains so data stays aligned with s_cs
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clock   (clock),
    .n_reset (n_reset),
    .d_in    (port_cs),
    .q_out   (s_cs)
  );

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sync_data
      sync_bit #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clock   (clock),
        .n_reset (n_reset),
        .d_in    (data_in[gi]),
        .q_out   (s_data[gi])
      );
    end
  endgenerate

  // FSM state and qualify counter registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      qual_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
    end
  end

  // Next-state logic: qualify s_cs for MIN_ASSERT edges, capture once, wait for release
  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_cs) begin
          state_d    = QUALIFY;
          qual_cnt_d = QUAL_CNT_W'(1);
        end
      end
      QUALIFY: begin
        if (!s_cs) begin
          // Too short: treat as a glitch and drop it
          state_d    = IDLE;
          qual_cnt_d = '0;
        end else if (qual_cnt_q == MIN_ASSERT_W) begin
          state_d    = CAPTURE;
          qual_cnt_d = '0;
        end else begin
          qual_cnt_d = qual_cnt_q + QUAL_CNT_W'(1);
        end
      end
      CAPTURE: begin
        // Already qualified; a select dropping here does not abort the write
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!s_cs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        qual_cnt_d = '0;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    capture_en = (state_q == CAPTURE);
    busy       = (state_q != IDLE);
  end

  // Held port register, single-cycle strobe and wrapping write counter
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      port_out_q     <= RESET_VALUE;
      write_strobe_q <= 1'b0;
      write_count_q  <= '0;
    end else begin
      write_strobe_q <= capture_en;
      if (capture_en) begin
        port_out_q    <= s_data;
        write_count_q <= write_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign port_out     = port_out_q;
  assign write_strobe = write_strobe_q;
  assign write_count  = write_count_q;

endmodule

// File: tb/tb_out_port_latch.sv
// Directed testbench for out_port_latch: default-parameter instance plus a
// COUNT_WIDTH=4 instance sharing the same stimulus for the wrap check.
module tb_out_port_latch;

  logic       clock = 1'b0;
  logic       n_reset;
  logic       port_cs;
  logic [7:0] data_in;

  logic [7:0] port_out, port_out_w4;
  logic       write_strobe, write_strobe_w4;
  logic [7:0] write_count;
  logic [3:0] write_count_w4;
  logic       busy, busy_w4;

  int checks = 0;
  int errors = 0;
  int strobe_seen = 0;
  int strobe_base;

  out_port_latch dut (
    .clock        (clock),
    .n_reset      (n_reset),
    .port_cs      (port_cs),
    .data_in      (data_in),
    .port_out     (port_out),
    .write_strobe (write_strobe),
    .write_count  (write_count),
    .busy         (busy)
  );

  out_port_latch #(.COUNT_WIDTH(4)) dut_w4 (
    .clock        (clock),
    .n_reset      (n_reset),
    .port_cs      (port_cs),
    .data_in      (data_in),
    .port_out     (port_out_w4),
    .write_strobe (write_strobe_w4),
    .write_count  (write_count_w4),
    .busy         (busy_w4)
  );

  always #5 clock = ~clock;

  // Count strobe cycles seen on the default instance, sampled away from the active edge
  always @(negedge clock) begin
    if (write_strobe === 1'b1) strobe_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge: select high for n_high edges, then low for n_low edges
  task automatic pulse(input logic [7:0] d, input int n_high, input int n_low);
    $display("write data=%02h high=%0d low=%0d", d, n_high, n_low);
    data_in = d;
    port_cs = 1'b1;
    repeat (n_high) @(negedge clock);
    port_cs = 1'b0;
    repeat (n_low) @(negedge clock);
  endtask

  initial begin
    n_reset = 1'b0;
    port_cs = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_port_out", port_out, 8'h00);
    chk("rst_strobe", write_strobe, 1'b0);
    chk("rst_count", write_count, 8'd0);
    chk("rst_busy", busy, 1'b0);
    n_reset = 1'b1;
    repeat (2) @(negedge clock);

    // Basic write: A5, select high 10 cycles; port_cs set before E0
    $display("write data=a5 high=10 (timed)");
    strobe_base = strobe_seen;
    data_in = 8'hA5;
    port_cs = 1'b1;
    repeat (5) @(negedge clock);              // after E4
    chk("basic_pre_port", port_out, 8'h00);
    chk("basic_pre_strobe", write_strobe, 1'b0);
    @(negedge clock);                         // after E5
    chk("basic_port_e5", port_out, 8'hA5);
    chk("basic_strobe_e5", write_strobe, 1'b1);
    chk("basic_count_e5", write_count, 8'd1);
    @(negedge clock);                         // after E6
    chk("basic_strobe_e6", write_strobe, 1'b0);
    repeat (3) @(negedge clock);              // after E9
    port_cs = 1'b0;
    repeat (2) @(negedge clock);              // after E11: s_cs just fell
    chk("basic_busy_e11", busy, 1'b1);
    @(negedge clock);                         // after E12
    chk("basic_busy_e12", busy, 1'b0);
    chk("basic_strobes", strobe_seen - strobe_base, 1);
    repeat (3) @(negedge clock);

    // Glitch: 2-cycle select is one short of the minimum
    strobe_base = strobe_seen;
    pulse(8'h3C, 2, 10);
    chk("glitch_port", port_out, 8'hA5);
    chk("glitch_count", write_count, 8'd1);
    chk("glitch_strobes", strobe_seen - strobe_base, 0);
    chk("glitch_busy", busy, 1'b0);

    // Boundary: 3-cycle select is exactly the minimum accepted width
    strobe_base = strobe_seen;
    pulse(8'h5A, 3, 10);
    chk("min_port", port_out, 8'h5A);
    chk("min_count", write_count, 8'd2);
    chk("min_strobes", strobe_seen - strobe_base, 1);

    // Held select: data changes mid-cycle, only the first value is captured
    $display("write data=11->22 high=100 (held)");
    strobe_base = strobe_seen;
    data_in = 8'h11;
    port_cs = 1'b1;
    repeat (20) @(negedge clock);
    data_in = 8'h22;
    repeat (80) @(negedge clock);
    chk("held_busy", busy, 1'b1);
    port_cs = 1'b0;
    repeat (6) @(negedge clock);
    chk("held_port", port_out, 8'h11);
    chk("held_count", write_count, 8'd3);
    chk("held_strobes", strobe_seen - strobe_base, 1);

    // Back-to-back writes with a 3-cycle gap
    strobe_base = strobe_seen;
    pulse(8'h01, 6, 3);
    pulse(8'h02, 6, 10);
    chk("b2b_port", port_out, 8'h02);
    chk("b2b_count", write_count, 8'd5);
    chk("b2b_count_w4", write_count_w4, 4'd5);
    chk("b2b_strobes", strobe_seen - strobe_base, 2);

    // Reset mid-cycle after a capture of 55, with select held through reset
    pulse(8'h55, 6, 6);
    chk("rmid_prior_port", port_out, 8'h55);
    $display("write data=66 high=held across reset");
    data_in = 8'h66;
    port_cs = 1'b1;
    repeat (3) @(negedge clock);              // after E2: in QUALIFY
    chk("rmid_busy_qual", busy, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    chk("rmid_port_async", port_out, 8'h00);
    chk("rmid_count_async", write_count, 8'd0);
    chk("rmid_busy_async", busy, 1'b0);
    @(negedge clock);
    n_reset = 1'b1;                           // next posedge is E0 after release
    repeat (5) @(negedge clock);              // after E4
    chk("rmid_pre_port", port_out, 8'h00);
    @(negedge clock);                         // after E5
    chk("rmid_port_e5", port_out, 8'h66);
    chk("rmid_strobe_e5", write_strobe, 1'b1);
    chk("rmid_count_e5", write_count, 8'd1);
    port_cs = 1'b0;
    repeat (6) @(negedge clock);

    // Wrap-around: 17 writes from reset on the 4-bit counter instance
    n_reset = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 17; i++) begin
      pulse(8'h10 + 8'(i), 6, 4);
    end
    repeat (4) @(negedge clock);
    chk("wrap_count_w4", write_count_w4, 4'd1);
    chk("wrap_count_w8", write_count, 8'd17);
    chk("wrap_port_w4", port_out_w4, 8'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_port_latch.md
# out_port_latch

Output-port register stage that consumes the port-FF chip select produced by the Z80 port decoder, on the CPU-clocked side. Samples the asynchronous chip select and the CPU data bus into the FPGA clock domain, and rejects glitches shorter than a programmable width. Captures exactly one byte per qualified OUT cycle into a held output register that drives the board outputs, such as LEDs. Emits a one-cycle write strobe and a running write count for downstream logic and debug.

## Interface
- SYNC_STAGES, 2: synchronizer depth for `port_cs` and `data_in`; legal range 2..4.
- MIN_ASSERT, 2: number of consecutive edges on which `s_cs` must be high before capture; legal range 1..15.
- RESET_VALUE, 8'h00: value of `port_out` during and after reset.
- COUNT_WIDTH, 8: width of `write_count`.
- clock  in  1  system clock; all state updates on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- port_cs  in  1  decoded OUT-port-FF select (active high); asynchronous to `clock`.
- data_in  in  8  Z80 data bus D0-D7; stable while `port_cs` is high.
- port_out  out  8  latched port value.
- write_strobe  out  1  one-cycle pulse when `port_out` is updated.
- write_count  out  COUNT_WIDTH  number of completed captures.
- busy  out  1  high while a write cycle is in progress (any state except IDLE).

## Operation
- Reset values: `port_out`=RESET_VALUE, `write_strobe`=0, `write_count`=0, `busy`=0, FSM=IDLE, all synchronizer flops cleared, qualify counter=0.
- `s_cs` is the output of the SYNC_STAGES-deep flop chain on `port_cs`. `s_data` is the output of an identical-depth chain on `data_in`, which keeps data aligned with `s_cs`.
- FSM states and transitions:
  - IDLE: if `s_cs`=1, go to QUALIFY with counter=1.
  - QUALIFY: if `s_cs`=0, go to IDLE and clear the counter; this is a glitch and nothing is updated. If `s_cs`=1 and counter==MIN_ASSERT, go to CAPTURE. Otherwise increment the counter.
  - CAPTURE: lasts exactly one cycle. On exit, `port_out`<=`s_data`, `write_strobe`<=1, and `write_count`<=`write_count`+1. Then go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until `s_cs`=0 is seen, then go to IDLE. A held-high chip select never causes a second capture.
- A chip select that drops while in CAPTURE does not abort the capture; the write is already qualified.
- `write_count` wraps modulo 2^COUNT_WIDTH; it does not saturate.
- `write_strobe` is registered and is cleared on the edge after it is set.
- `port_out` holds its value indefinitely between captures.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously) and the in-flight write is discarded. If `port_cs` is still high after reset releases, it is qualified afresh as a new write.

## Timing
- Define E0 as the first rising edge at which the first synchronizer flop samples `port_cs`=1.
- `s_cs`=1 after E(SYNC_STAGES-1).
- QUALIFY is entered at E(SYNC_STAGES).
- CAPTURE is entered at E(SYNC_STAGES+MIN_ASSERT).
- `port_out`, `write_strobe` and `write_count` update at E(SYNC_STAGES+MIN_ASSERT+1). With the default parameters this is E5.
- `write_strobe` falls at E(SYNC_STAGES+MIN_ASSERT+2).
- Minimum `port_cs` width for acceptance is MIN_ASSERT+1 clock periods. Any shorter pulse is rejected.
- After `s_cs` falls, the FSM returns to IDLE one edge later. A new write can then start qualifying on the next edge.
- `data_in` must be stable from E0 until E(SYNC_STAGES+MIN_ASSERT).

## Structure
- Shared package `port_pkg`:
  - state encoding: IDLE=2'd0, QUALIFY=2'd1, CAPTURE=2'd2, WAIT_RELEASE=2'd3;
  - default port reset value constant;
  - port-FF address constant 8'hFF, shared with the decoder.
- Sub-module `sync_bit`: an N-stage synchronizer (parameter STAGES) with async active-low clear. Instantiate it once for `port_cs` and eight times (or vectorised) for `data_in`.
- Remaining logic (FSM, qualify counter, output registers) lives flat in `out_port_latch`.

## Test plan
- Basic write: default parameters, `data_in`=8'hA5, `port_cs` high for 10 cycles. Expect `port_out`=8'hA5 at E5, `write_strobe` high for exactly one cycle, `write_count`=1, and `busy` low 1 edge after `s_cs` falls.
- Glitch rejection: `port_cs` high for 2 cycles with `data_in`=8'h3C. Expect `port_out` to stay 8'h00, no strobe, and `write_count`=0.
- Held select: `port_cs` high for 100 cycles while `data_in` changes from 8'h11 to 8'h22 at cycle 20. Expect a single capture of 8'h11 and `write_count`=1.
- Back-to-back writes: 8'h01 then 8'h02, with each select high 6 cycles and a 3-cycle gap. Expect two strobes, `port_out`=8'h02, and `write_count`=2.
- Wrap-around: COUNT_WIDTH=4, perform 17 qualified writes. Expect `write_count`=1 after the 17th write.
- Reset mid-cycle: assert `n_reset` during QUALIFY after a prior capture of 8'h55. Expect `port_out`=8'h00 immediately. With `port_cs` still high at reset release, expect a fresh capture at E5 after release.
